// File: rtl/halt_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | halt_monitor: watches the retiring PC/IR stream and raises a sticky halt    |
// | with an encoded cause. Optional PC trace ring: HALT_MONITOR_TRACE_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module halt_monitor #(
  parameter int          PC_W        = 32,
  parameter int          IR_W        = 32,
  parameter int          NOP_LIMIT   = 6,
  parameter int          CYC_W       = 32,
  parameter int unsigned CYC_LIMIT   = 10000000,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic                           w_clk,
  input  logic                           w_rst,
  input  logic                           w_valid,
  input  logic [PC_W-1:0]                w_pc,
  input  logic [IR_W-1:0]                w_ir,
  input  logic                           w_ext_halt,
  output logic                           w_halt,
  output logic [2:0]                     w_cause,
  output logic [PC_W-1:0]                w_halt_pc,
  output logic [CYC_W-1:0]               w_cycle,
  output logic [3:0]                     w_nopcnt,
  input  logic [$clog2(TRACE_DEPTH)-1:0] w_trace_idx,
  output logic [PC_W-1:0]                w_trace_pc
);

  localparam int               c_TIDX_W    = $clog2(TRACE_DEPTH);
  localparam logic [3:0]       c_NOP_LIMIT = 4'(NOP_LIMIT);
  localparam logic [3:0]       c_NOP_LAST  = 4'(NOP_LIMIT - 1);
  localparam logic [CYC_W-1:0] c_CYC_LIMIT = CYC_W'(CYC_LIMIT);

  localparam logic [2:0] c_CAUSE_NONE     = 3'd0;
  localparam logic [2:0] c_CAUSE_NOP      = 3'd1;
  localparam logic [2:0] c_CAUSE_MISALIGN = 3'd2;
  localparam logic [2:0] c_CAUSE_EXT      = 3'd3;
  localparam logic [2:0] c_CAUSE_LIMIT    = 3'd4;

  if (NOP_LIMIT < 1 || NOP_LIMIT > 15) begin : g_bad_nop_limit
    $error("halt_monitor: NOP_LIMIT must be in 1..15");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_trace_depth
    $error("halt_monitor: TRACE_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_halt;
  logic [2:0]       r_cause;
  logic [PC_W-1:0]  r_halt_pc;
  logic [CYC_W-1:0] r_cycle;
  logic [3:0]       r_nopcnt;

  logic       w_is_nop;
  logic       w_c_misalign;
  logic       w_c_nop;
  logic       w_c_ext;
  logic       w_c_limit;
  logic       w_any_halt;
  logic [2:0] w_cause_nxt;
  logic [3:0] w_nopcnt_nxt;

  assign w_is_nop     = w_valid && (w_ir == '0);
  assign w_c_misalign = w_valid && (w_pc[1:0] != 2'b00);
  assign w_c_nop      = w_is_nop && (r_nopcnt == c_NOP_LAST);
  assign w_c_ext      = w_ext_halt;
  assign w_c_limit    = (CYC_LIMIT != 0) && (r_cycle == c_CYC_LIMIT);
  assign w_any_halt   = w_c_misalign || w_c_nop || w_c_ext || w_c_limit;

  always_comb begin
    w_cause_nxt = c_CAUSE_NONE;
    if (w_c_misalign)   w_cause_nxt = c_CAUSE_MISALIGN;
    else if (w_c_nop)   w_cause_nxt = c_CAUSE_NOP;
    else if (w_c_ext)   w_cause_nxt = c_CAUSE_EXT;
    else if (w_c_limit) w_cause_nxt = c_CAUSE_LIMIT;
  end

  // Bubbles (w_valid=0) neither advance nor break a NOP run.
  always_comb begin
    w_nopcnt_nxt = r_nopcnt;
    if (w_valid) begin
      if (!w_is_nop)                     w_nopcnt_nxt = 4'd0;
      else if (r_nopcnt != c_NOP_LIMIT)  w_nopcnt_nxt = r_nopcnt + 4'd1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state   <= S_RUN;
      r_halt    <= 1'b0;
      r_cause   <= c_CAUSE_NONE;
      r_halt_pc <= '0;
      r_cycle   <= '0;
      r_nopcnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_nopcnt <= w_nopcnt_nxt;
      if (w_any_halt) begin
        r_state   <= S_HALT;
        r_halt    <= 1'b1;
        r_cause   <= w_cause_nxt;
        r_halt_pc <= w_pc;
      end else begin
        r_cycle <= r_cycle + CYC_W'(1);
      end
    end
  end

  assign w_halt    = r_halt;
  assign w_cause   = r_cause;
  assign w_halt_pc = r_halt_pc;
  assign w_cycle   = r_cycle;
  assign w_nopcnt  = r_nopcnt;

`ifdef HALT_MONITOR_TRACE_EN
  logic [PC_W-1:0]        r_trace_mem [TRACE_DEPTH];
  logic [TRACE_DEPTH-1:0] r_trace_vld;
  logic [c_TIDX_W-1:0]    r_wptr;
  logic [c_TIDX_W-1:0]    w_rd_ptr;
  logic                   w_trace_we;

  assign w_trace_we = !w_rst && (r_state == S_RUN) && w_valid;

  // Storage is deliberately left out of reset; the valid bits mask stale data.
  always_ff @(posedge w_clk) begin
    if (w_trace_we) r_trace_mem[r_wptr] <= w_pc;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_wptr      <= '0;
      r_trace_vld <= '0;
    end else if (w_trace_we) begin
      r_wptr              <= r_wptr + c_TIDX_W'(1);
      r_trace_vld[r_wptr] <= 1'b1;
    end
  end

  assign w_rd_ptr   = r_wptr - c_TIDX_W'(1) - w_trace_idx;
  assign w_trace_pc = r_trace_vld[w_rd_ptr] ? r_trace_mem[w_rd_ptr] : '0;
`else
  logic w_unused_trace_idx;
  assign w_unused_trace_idx = ^w_trace_idx;
  assign w_trace_pc         = '0;
`endif

endmodule
`default_nettype wire
